// File: rtl/piezo_melody_seq_if.sv
// Control/status and melody-ROM signals of the piezo melody sequencer.
// The slave modport is the sequencer; the master side is the alarm controller plus the note ROM.
`timescale 1ns/1ps
interface piezo_melody_seq_if #(
  parameter int PERIOD_W = 8,
  parameter int STEP_W   = 6,
  parameter int SEL_W    = 1
);
  logic                      enable;
  logic                      start;
  logic                      stop;
  logic [SEL_W-1:0]          song_sel;
  logic                      loop_en;
  logic [SEL_W+STEP_W-1:0]   note_addr;
  logic [PERIOD_W-1:0]       note_data;
  logic                      piezo;
  logic                      busy;
  logic                      done;
  logic [STEP_W-1:0]         step;

  modport slave (
    input  enable, start, stop, song_sel, loop_en, note_data,
    output note_addr, piezo, busy, done, step
  );

  modport master (
    output enable, start, stop, song_sel, loop_en, note_data,
    input  note_addr, piezo, busy, done, step
  );
endinterface

// File: rtl/piezo_melody_seq.sv
// Melody sequencer: steps through a song in an external zero-latency note ROM and
// drives the piezo with a square wave whose half-period is the note code.
`timescale 1ns/1ps
module piezo_melody_seq #(
  parameter int NOTE_TICKS = 500,
  parameter int GAP_TICKS  = 50,
  parameter int PERIOD_W   = 8,
  parameter int STEP_W     = 6,
  parameter int SEL_W      = 1
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  piezo_melody_seq_if.slave bus
);

  localparam int TICK_W = (NOTE_TICKS > 2) ? $clog2(NOTE_TICKS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(NOTE_TICKS - 1);

  typedef enum logic {IDLE, PLAY} state_e;

  state_e                    state_q;
  logic [SEL_W-1:0]          song_q;
  logic [STEP_W-1:0]         step_q;
  logic [SEL_W+STEP_W-1:0]   addr_q;
  logic [TICK_W-1:0]         tick_q;
  logic [PERIOD_W-1:0]       tone_q;
  logic [PERIOD_W-1:0]       note_q;
  logic                      piezo_q;
  logic                      busy_q;
  logic                      done_q;

  logic [TICK_W-1:0]         tick_d;
  logic [PERIOD_W-1:0]       tone_d;
  logic [STEP_W-1:0]         step_d;
  logic                      start_ok;
  logic                      in_gap;
  logic                      tick_last;
  logic                      step_last;
  logic                      tone_hit;

  assign tick_d    = tick_q + TICK_W'(1);
  assign tone_d    = tone_q + PERIOD_W'(1);
  assign step_d    = step_q + STEP_W'(1);
  assign start_ok  = bus.start && bus.enable && !bus.stop;
  assign tick_last = (tick_q == TICK_LAST);
  assign step_last = (step_q == {STEP_W{1'b1}});
  assign tone_hit  = (tone_q == note_q - PERIOD_W'(1));
  // Compared at 32 bits so GAP_TICKS=0 (gap start == NOTE_TICKS) cannot wrap.
  assign in_gap    = ($unsigned(32'(tick_q)) >= $unsigned(32'(NOTE_TICKS - GAP_TICKS)));

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q <= IDLE;
      song_q  <= '0;
      step_q  <= '0;
      addr_q  <= '0;
      tick_q  <= '0;
      tone_q  <= '0;
      note_q  <= '0;
      piezo_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            state_q <= PLAY;
            busy_q  <= 1'b1;
            song_q  <= bus.song_sel;
            step_q  <= '0;
            addr_q  <= {bus.song_sel, {STEP_W{1'b0}}};
            tick_q  <= '0;
            tone_q  <= '0;
            piezo_q <= 1'b0;
          end
        end
        PLAY: begin
          if (bus.stop || !bus.enable) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            piezo_q <= 1'b0;
            step_q  <= '0;
            addr_q  <= {song_q, {STEP_W{1'b0}}};
            tick_q  <= '0;
            tone_q  <= '0;
          end else if (bus.start) begin
            song_q  <= bus.song_sel;
            step_q  <= '0;
            addr_q  <= {bus.song_sel, {STEP_W{1'b0}}};
            tick_q  <= '0;
            tone_q  <= '0;
            piezo_q <= 1'b0;
          end else begin
            // Tick 0 latches the note; the address settled on the previous edge.
            if (tick_q == '0) begin
              note_q <= bus.note_data;
              tone_q <= '0;
            end else if (in_gap) begin
              piezo_q <= 1'b0;
              tone_q  <= '0;
            end else if (note_q == '0) begin
              piezo_q <= 1'b0;
            end else if (tone_hit) begin
              tone_q  <= '0;
              piezo_q <= ~piezo_q;
            end else begin
              tone_q <= tone_d;
            end

            if (tick_last) begin
              tick_q <= '0;
              if (!step_last) begin
                step_q <= step_d;
                addr_q <= {song_q, step_d};
              end else if (bus.loop_en) begin
                step_q <= '0;
                addr_q <= {song_q, {STEP_W{1'b0}}};
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                piezo_q <= 1'b0;
                tone_q  <= '0;
                step_q  <= '0;
                addr_q  <= {song_q, {STEP_W{1'b0}}};
              end
            end else begin
              tick_q <= tick_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.note_addr = addr_q;
  assign bus.piezo     = piezo_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.step      = step_q;

endmodule

// File: tb/tb_piezo_melody_seq.sv
// Directed bench for piezo_melody_seq: expected outputs are derived from song position
// arithmetic, queued before each clock edge and popped once the edge has been taken.
`timescale 1ns/1ps
module tb_piezo_melody_seq;

  localparam int NT        = 20;
  localparam int GT        = 4;
  localparam int SOUND_END = NT - GT;
  localparam int STEPS     = 4;
  localparam int SONG_CYC  = NT * STEPS;

  typedef struct packed {
    logic       piezo;
    logic       busy;
    logic       done;
    logic [1:0] step;
    logic [2:0] addr;
  } obs_t;

  localparam obs_t IDLE0 = '{piezo: 1'b0, busy: 1'b0, done: 1'b0, step: 2'd0, addr: 3'd0};

  logic clk = 1'b0;
  logic resetn;
  int   vectors = 0;
  int   miscompares = 0;
  int   songNotes [2][4] = '{'{3, 3, 0, 2}, '{5, 0, 5, 0}};
  obs_t expQ [$];

  piezo_melody_seq_if #(.PERIOD_W(8), .STEP_W(2), .SEL_W(1)) bus ();

  piezo_melody_seq #(
    .NOTE_TICKS(NT), .GAP_TICKS(GT), .PERIOD_W(8), .STEP_W(2), .SEL_W(1)
  ) dut (
    .clk_i   (clk),
    .resetn_i(resetn),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  assign bus.note_data = 8'(songNotes[bus.note_addr[2]][bus.note_addr[1:0]]);

  // Piezo level seen at tick t of a step: toggles land on ticks n+1, 2n+1, ... up to the gap.
  function automatic logic expPiezo(input int n, input int t);
    int k;
    if (n == 0 || t == 0 || t > SOUND_END) return 1'b0;
    k = (t - 1) / n;
    if (k > (SOUND_END - 1) / n) k = (SOUND_END - 1) / n;
    return k[0];
  endfunction

  function automatic obs_t expAt(input int song, input int c, input int passes);
    obs_t e;
    int   s;
    if (c < SONG_CYC * passes) begin
      s = (c / NT) % STEPS;
      e.piezo = expPiezo(songNotes[song][s], c % NT);
      e.busy  = 1'b1;
      e.done  = 1'b0;
      e.step  = 2'(s);
      e.addr  = 3'(song * STEPS + s);
    end else begin
      e.piezo = 1'b0;
      e.busy  = 1'b0;
      e.done  = (c == SONG_CYC * passes);
      e.step  = 2'd0;
      e.addr  = 3'(song * STEPS);
    end
    return e;
  endfunction

  task automatic applyStimulus(input logic en, input logic st, input logic sp, input logic sel);
    bus.enable   = en;
    bus.start    = st;
    bus.stop     = sp;
    bus.song_sel = sel;
  endtask

  task automatic checkOutput(input string tag, input obs_t e);
    obs_t got;
    obs_t want;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    got  = obs_t'({bus.piezo, bus.busy, bus.done, bus.step, bus.note_addr});
    want = expQ.pop_front();
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("[TB] FAIL %s t=%0t got p=%b b=%b d=%b s=%0d a=%0d want p=%b b=%b d=%b s=%0d a=%0d",
             tag, $time, got.piezo, got.busy, got.done, got.step, got.addr,
             want.piezo, want.busy, want.done, want.step, want.addr);
    end
  endtask

  task automatic runSong(input string tag, input int song, input int passes,
                         input int cFrom, input int cTo, input int dropLoopAt);
    for (int c = cFrom; c <= cTo; c++) begin
      if (c == dropLoopAt) bus.loop_en = 1'b0;
      checkOutput(tag, expAt(song, c, passes));
    end
  endtask

  initial begin
    resetn = 1'b0;
    bus.loop_en = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++) checkOutput("reset", IDLE0);
    resetn = 1'b1;
    for (int i = 0; i < 10; i++) checkOutput("idle", IDLE0);

    // One-shot song 0: DONE on cycle 80 after the START edge.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("oneshot_start", expAt(0, 0, 1));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    runSong("oneshot", 0, 1, 1, 85, -1);

    // Looping song 1; LOOP dropped mid third pass ends it at the pass boundary.
    bus.loop_en = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("loop_start", expAt(1, 0, 3));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    runSong("loop", 1, 3, 1, 245, 210);

    // STOP together with START during step 1 aborts without restart.
    bus.loop_en = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("abort_start", expAt(0, 0, 1));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    runSong("abort_play", 0, 1, 1, 25, -1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("abort_edge", IDLE0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) checkOutput("abort_idle", IDLE0);

    // ENABLE drop mid-step, START while disabled, then restart in PLAY with a new song.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("en_start", expAt(0, 0, 1));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    runSong("en_play", 0, 1, 1, 12, -1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("en_drop", IDLE0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("start_disabled", IDLE0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("reenable_idle", IDLE0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("re_start", expAt(0, 0, 1));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    runSong("re_play", 0, 1, 1, 30, -1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("restart_sel1", expAt(1, 0, 1));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    runSong("restart_play", 1, 1, 1, 47, -1);

    // Reset at tick 7 of step 2.
    resetn = 1'b0;
    checkOutput("midreset", IDLE0);
    for (int i = 0; i < 2; i++) checkOutput("midreset_hold", IDLE0);
    resetn = 1'b1;
    for (int i = 0; i < 90; i++) checkOutput("post_reset", IDLE0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/piezo_melody_seq.md
Name: piezo_melody_seq

Overview:
- Parametrised successor to the alarm piezo driver: plays a selectable melody from an external note ROM as a square wave on the piezo pin.
- Adds song select, loop/one-shot mode, per-step articulation gap, start/stop control, and busy/done status.
- Sits between the alarm controller (start/stop, enable) and a small melody ROM. Drives the board piezo directly.

Parameters:
- NOTE_TICKS, 500, clock cycles per melody step (>=2)
- GAP_TICKS, 50, silent cycles at the end of every step (0 <= GAP_TICKS < NOTE_TICKS)
- PERIOD_W, 8, width of a note code (half-period in clock cycles; 0 = rest)
- STEP_W, 6, log2 of steps per song; SONG_LEN = 2**STEP_W
- SEL_W, 1, song-select width; 2**SEL_W songs

Ports:
- CLK  in  1  system clock
- RESETN  in  1  synchronous active-low reset
- ENABLE  in  1  alarm enable; low forces idle and silence
- START  in  1  one-cycle pulse: begin song SONG_SEL at step 0
- STOP  in  1  one-cycle pulse: abort playback
- SONG_SEL  in  SEL_W  song index, sampled on accepted START
- LOOP  in  1  1 = repeat song forever; 0 = one-shot; sampled continuously
- NOTE_ADDR  out  SEL_W+STEP_W  ROM address {song_reg, step}, registered
- NOTE_DATA  in  PERIOD_W  ROM data, combinational from NOTE_ADDR
- PIEZO  out  1  square-wave output, registered
- BUSY  out  1  high while in PLAY
- DONE  out  1  one-cycle pulse when a one-shot song completes
- STEP  out  STEP_W  current step index

Behaviour:
- Reset (RESETN=0 at a CLK edge): state IDLE; PIEZO, BUSY, DONE, STEP, NOTE_ADDR, tick, tone counter, and note_reg are all 0.
- States: IDLE, PLAY.
- IDLE -> PLAY: START=1, ENABLE=1, STOP=0.
  - On that edge: song_reg<=SONG_SEL, step<=0, tick<=0, tone_cnt<=0, PIEZO<=0, BUSY<=1.
- PLAY -> IDLE, next edge: STOP=1 or ENABLE=0.
  - PIEZO<=0, BUSY<=0, step<=0, no DONE.
  - STOP has priority over a simultaneous START.
- START in PLAY (no STOP, ENABLE=1): restart at step 0 with the newly sampled SONG_SEL, tick<=0, PIEZO<=0.
- Step timing, in PLAY:
  - tick counts 0..NOTE_TICKS-1.
  - At tick==0, note_reg<=NOTE_DATA (address already stable from the previous edge) and tone_cnt<=0.
- Sounding window is tick 1..NOTE_TICKS-GAP_TICKS-1:
  - If note_reg!=0: when tone_cnt==note_reg-1, tone_cnt<=0 and PIEZO<=~PIEZO; else tone_cnt++.
  - Result: half-period of note_reg cycles, first toggle note_reg cycles after load.
  - If note_reg==0 (rest): PIEZO held 0.
- Gap window is tick >= NOTE_TICKS-GAP_TICKS: PIEZO<=0, tone_cnt<=0.
- End of step (tick==NOTE_TICKS-1): tick<=0.
  - step<SONG_LEN-1: step++.
  - Last step, LOOP=1: step<=0, stay in PLAY.
  - Last step, LOOP=0: go to IDLE, BUSY<=0, DONE<=1 for exactly one cycle, PIEZO<=0.
- NOTE_ADDR = {song_reg, step}, registered and updated on the same edge as step. ROM read is zero-latency.
- Counters wrap only as described above; no other overflow is possible given the parameter constraints.
- RESETN low mid-song: immediate return to reset values on that edge.
- START while ENABLE=0: ignored.

Test Plan (NOTE_TICKS=20, GAP_TICKS=4, STEP_W=2, SEL_W=1, PERIOD_W=8):
- Reset then idle: hold RESETN=0 for 3 cycles, release -> PIEZO=0, BUSY=0, DONE=0, NOTE_ADDR=0 for 10 cycles with no START.
- One-shot tone: ROM song0 = {3,3,0,2}, LOOP=0, START with SONG_SEL=0 -> BUSY=1.
  - Step0 PIEZO: half-period 3 cycles during ticks 1..15, 0 during ticks 16..19.
  - Step2 silent; step3 half-period 2.
  - DONE pulses once 80 cycles after START; BUSY=0 afterwards.
- Loop and select: song1 = {5,0,5,0}, SONG_SEL=1, LOOP=1 -> NOTE_ADDR sequence 4,5,6,7,4,...
  - No DONE after 200 cycles.
  - Drop LOOP -> stops at the end of the current pass with one DONE.
- Abort: during step1 of song0 assert STOP together with START -> IDLE next edge, PIEZO=0, BUSY=0, no DONE, no restart.
- ENABLE drop / restart: ENABLE=0 mid-step -> silence and IDLE next edge.
  - Re-enable and START in PLAY with SONG_SEL changed -> step=0, new song address.
- Reset mid-song: RESETN=0 at tick 7 of step 2 -> all outputs 0 on that edge; no DONE after release.
